// File: rtl/riscv_pkg.sv
// Shared constants for the multi-cycle RISC-V sequencer: RV32I major opcodes,
// FSM state encoding, trap-cause codes and the reset value of the IR.
package riscv_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // Sequencer FSM state encoding
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR  = 2'b10;

  // ADDI x0, x0, 0 -- the canonical NOP held in the IR out of reset
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/riscv_opclass.sv
// Combinational opcode classifier: sorts an instruction word into the
// classes the sequencer needs to pick its path through EXEC/MEM/WB.
module riscv_opclass
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_fence,
  output logic        is_illegal
);

  logic [6:0] opcode;
  logic       unused_hi;

  assign opcode    = instr[6:0];
  assign unused_hi = ^instr[31:7];

  // Decode the major opcode; anything outside the RV32I base set is illegal
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_fence   = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OPC_LOAD:     is_load   = 1'b1;
      OPC_STORE:    is_store  = 1'b1;
      OPC_BRANCH:   is_branch = 1'b1;
      OPC_MISC_MEM: is_fence  = 1'b1;
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: ;
      default:      is_illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) begin
      is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/riscv_mc_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB],
// with bounded memory handshakes, illegal/bus-error traps and a retire counter.
module riscv_mc_sequencer
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
  parameter int              MAX_WAIT = 15,
  parameter int              CNT_W    = 32
) (
  input  logic             adc_sck,
  input  logic             reset,
  input  logic             halt,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  next_pc,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic             pc_we,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT);

  logic [2:0]        state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              fetchIssued_q, fetchIssued_d;
  logic [1:0]        cause_q, cause_d;

  logic imemReq, dmemReq, dmemWe, rfWe, pcWe, trapPulse;
  logic isLoad, isStore, isBranch, isFence, isIllegal;

  riscv_opclass u_opclass (
    .instr      (instr_q),
    .is_load    (isLoad),
    .is_store   (isStore),
    .is_branch  (isBranch),
    .is_fence   (isFence),
    .is_illegal (isIllegal)
  );

  // Next-state, handshake and strobe logic; a state change always restarts the wait count.
  // fetchIssued keeps an outstanding fetch alive if halt rises while waiting for imem_ready.
  // A STORE retires in MEM by updating pc silently so pc_we never overlaps dmem_req.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instret_d     = instret_q;
    waitCnt_d     = waitCnt_q;
    fetchIssued_d = fetchIssued_q;
    cause_d       = cause_q;
    imemReq       = 1'b0;
    dmemReq       = 1'b0;
    dmemWe        = 1'b0;
    rfWe          = 1'b0;
    pcWe          = 1'b0;
    trapPulse     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imemReq = ~halt | fetchIssued_q;
        if (imemReq) begin
          if (imem_ready) begin
            instr_d = imem_rdata;
            state_d = ST_DECODE;
          end else if (waitCnt_q == WAIT_LAST) begin
            cause_d = CAUSE_BUSERR;
            state_d = ST_TRAP;
          end else begin
            waitCnt_d     = waitCnt_q + WAIT_W'(1);
            fetchIssued_d = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        if (isIllegal) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (isLoad || isStore) begin
          state_d = ST_MEM;
        end else if (isBranch || isFence) begin
          pcWe      = 1'b1;
          pc_d      = next_pc;
          instret_d = instret_q + CNT_W'(1);
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmemReq = 1'b1;
        dmemWe  = isStore;
        if (dmem_ready) begin
          if (isStore) begin
            pc_d      = next_pc;
            instret_d = instret_q + CNT_W'(1);
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (waitCnt_q == WAIT_LAST) begin
          cause_d = CAUSE_BUSERR;
          state_d = ST_TRAP;
        end else begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        rfWe      = 1'b1;
        pcWe      = 1'b1;
        pc_d      = next_pc;
        instret_d = instret_q + CNT_W'(1);
        state_d   = ST_FETCH;
      end
      ST_TRAP: begin
        trapPulse = 1'b1;
        pc_d      = TRAP_VEC;
        state_d   = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    if (state_d != state_q) begin
      waitCnt_d     = '0;
      fetchIssued_d = 1'b0;
    end
  end

  // Architectural and control registers with synchronous reset
  always_ff @(posedge adc_sck) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instret_q     <= '0;
      waitCnt_q     <= '0;
      fetchIssued_q <= 1'b0;
      cause_q       <= CAUSE_NONE;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instret_q     <= instret_d;
      waitCnt_q     <= waitCnt_d;
      fetchIssued_q <= fetchIssued_d;
      cause_q       <= cause_d;
    end
  end

  // Requests and strobes are forced low for as long as reset is held
  assign imem_req   = imemReq   & ~reset;
  assign dmem_req   = dmemReq   & ~reset;
  assign dmem_we    = dmemWe    & ~reset;
  assign rf_we      = rfWe      & ~reset;
  assign pc_we      = pcWe      & ~reset;
  assign trap       = trapPulse & ~reset;
  assign trap_cause = trap ? cause_q : CAUSE_NONE;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule
